vrf_read_req_gen: RTL

- Request sequencer directly upstream of the VRF read pipe stage (vrf_read_pipe).
- Accepts one read command per instruction operand and walks the group/offset space, emitting one read request per beat into the read pipe's enqueue port.
- Holds a credit counter sized to the read pipe's 4-entry data queue, so outstanding reads never exceed the buffering available downstream.
- Reports completion or abort once every issued read has been dequeued.

---
 rtl/vrf_read_pkg.sv | 27 ++
 rtl/read_credit_counter.sv | 52 +++++
 rtl/vrf_read_req_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vrf_read_pkg.sv
// Types and constants shared by the VRF read request generator and the read pipe.
package vrf_read_pkg;

    localparam int VRF_VS_W     = 5;
    localparam int VRF_OFFSET_W = 5;
    localparam int VRF_GROUP_W  = 4;
    localparam int VRF_SRC_W    = 4;
    localparam int VRF_IDX_W    = 3;

    // Depth of the read pipe's data queue; producers size their credits to it.
    localparam int READ_QUEUE_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } vrf_read_state_e;

    typedef struct packed {
        logic [VRF_VS_W-1:0]     vs;
        logic [VRF_OFFSET_W-1:0] offset;
        logic [VRF_GROUP_W-1:0]  groupIndex;
        logic [VRF_SRC_W-1:0]    readSource;
        logic [VRF_IDX_W-1:0]    instructionIndex;
    } vrf_read_req_t;

endpackage

// File: rtl/read_credit_counter.sv
// Up/down credit counter for read-pipe producers: counts reads in flight,
// saturating at 0 and at MAX_COUNT.
module read_credit_counter
    import vrf_read_pkg::*;
#(
    parameter int MAX_COUNT = READ_QUEUE_DEPTH
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic has_credit,
    output logic empty
);

    localparam int CNT_W = $clog2(MAX_COUNT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             dec_eff, inc_eff;

    always_comb begin
        dec_eff = dec & (count_q != '0);
        inc_eff = inc & ((count_q != MAX_CNT) | dec_eff);
        count_d = count_q;
        if (inc_eff & ~dec_eff) begin
            count_d = count_q + ONE;
        end else if (dec_eff & ~inc_eff) begin
            count_d = count_q - ONE;
        end
        // A return this cycle frees its slot for an issue in the same cycle.
        has_credit = (count_q != MAX_CNT) | dec_eff;
        // Emptiness after this cycle's update, so a drain can finish without a bubble.
        empty      = (count_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            no_return_underflow: assert (!(dec && (count_q == '0)));
        end
    end

endmodule

// File: rtl/vrf_read_req_gen.sv
// Walks the group/offset space of one operand read command, issuing one request
// per beat into vrf_read_pipe while holding no more reads than its queue can take.
module vrf_read_req_gen
    import vrf_read_pkg::*;
#(
    parameter int VS_W            = VRF_VS_W,
    parameter int OFFSET_W        = VRF_OFFSET_W,
    parameter int GROUP_W         = VRF_GROUP_W,
    parameter int SRC_W           = VRF_SRC_W,
    parameter int IDX_W           = VRF_IDX_W,
    parameter int MAX_OUTSTANDING = READ_QUEUE_DEPTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [VS_W-1:0]     cmd_vs,
    input  logic [OFFSET_W-1:0] cmd_offsetLast,
    input  logic [GROUP_W-1:0]  cmd_groupLast,
    input  logic [SRC_W-1:0]    cmd_readSource,
    input  logic [IDX_W-1:0]    cmd_instructionIndex,
    input  logic                kill,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [VS_W-1:0]     req_vs,
    output logic [OFFSET_W-1:0] req_offset,
    output logic [GROUP_W-1:0]  req_groupIndex,
    output logic [SRC_W-1:0]    req_readSource,
    output logic [IDX_W-1:0]    req_instructionIndex,
    input  logic                resp_fire,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    // Handshakes: a transfer happens on a cycle where valid & ready are both high.
    // req_valid never depends on req_ready; req_* hold steady while stalled.

    vrf_read_state_e state_q, state_d;

    logic [VS_W-1:0]     vs_q, vs_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [OFFSET_W-1:0] offset_last_q, offset_last_d;
    logic [GROUP_W-1:0]  group_q, group_d;
    logic [GROUP_W-1:0]  group_last_q, group_last_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                abort_q, abort_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;

    logic has_credit;
    logic drained;
    logic cmd_fire;
    logic issue_en;
    logic req_fire;
    logic last_offset;
    logic last_beat;

    read_credit_counter #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_credit (
        .clock      (clock),
        .reset      (reset),
        .inc        (req_fire),
        .dec        (resp_fire),
        .has_credit (has_credit),
        .empty      (drained)
    );

    always_comb begin
        // The done cycle is still closing the old command, so hold off acceptance.
        cmd_ready   = (state_q == ST_IDLE) & ~done_q;
        cmd_fire    = cmd_valid & cmd_ready;
        issue_en    = (state_q == ST_ISSUE) & has_credit & ~kill;
        req_fire    = issue_en & req_ready;
        last_offset = (offset_q == offset_last_q);
        last_beat   = last_offset & (group_q == group_last_q);

        state_d       = state_q;
        vs_d          = vs_q;
        offset_d      = offset_q;
        offset_last_d = offset_last_q;
        group_d       = group_q;
        group_last_d  = group_last_q;
        src_d         = src_q;
        idx_d         = idx_q;
        abort_d       = abort_q;
        done_d        = 1'b0;
        aborted_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    vs_d          = cmd_vs;
                    offset_last_d = cmd_offsetLast;
                    group_last_d  = cmd_groupLast;
                    src_d         = cmd_readSource;
                    idx_d         = cmd_instructionIndex;
                    offset_d      = '0;
                    group_d       = '0;
                    abort_d       = 1'b0;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (kill) begin
                    abort_d = 1'b1;
                    state_d = ST_DRAIN;
                end else if (req_fire) begin
                    if (last_beat) begin
                        offset_d = '0;
                        group_d  = '0;
                        state_d  = ST_DRAIN;
                    end else if (last_offset) begin
                        offset_d = '0;
                        group_d  = group_q + GROUP_W'(1);
                    end else begin
                        offset_d = offset_q + OFFSET_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                abort_d = abort_q | kill;
                if (drained) begin
                    done_d    = 1'b1;
                    aborted_d = abort_d;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            vs_q          <= '0;
            offset_q      <= '0;
            offset_last_q <= '0;
            group_q       <= '0;
            group_last_q  <= '0;
            src_q         <= '0;
            idx_q         <= '0;
            abort_q       <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vs_d;
            offset_q      <= offset_d;
            offset_last_q <= offset_last_d;
            group_q       <= group_d;
            group_last_q  <= group_last_d;
            src_q         <= src_d;
            idx_q         <= idx_d;
            abort_q       <= abort_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
        end
    end

    assign req_valid            = issue_en;
    assign req_vs               = vs_q;
    assign req_offset           = offset_q;
    assign req_groupIndex       = group_q;
    assign req_readSource       = src_q;
    assign req_instructionIndex = idx_q;
    assign busy                 = (state_q != ST_IDLE);
    assign done                 = done_q;
    assign aborted              = aborted_q;

endmodule
